booth_seq_mult: RTL and testbench
=================================

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (signed two's complement, minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply of a and b.
REQ-005 The block SHALL have port a, input, WIDTH bits: signed multiplicand, sampled on start acceptance.
REQ-006 The block SHALL have port b, input, WIDTH bits: signed multiplier, sampled on start acceptance.
REQ-007 The block SHALL have port busy, output, 1 bit: a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that product is valid.
REQ-009 The block SHALL have port product, output, 2*WIDTH bits: signed result, registered.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and DONE.
REQ-011 start SHALL be accepted only in IDLE or DONE; on acceptance:
- M <= sign-extended a (WIDTH+1 bits)
- Q <= b
- A <= 0 (WIDTH+1 bits)
- q_1 <= 0
- count <= 0
- state <= CALC
REQ-012 start asserted in CALC SHALL be ignored; operands and the in-flight result are unaffected.
REQ-013 Each CALC cycle SHALL perform one radix-2 Booth step on {Q[0],q_1}:
- 10: A-M
- 01: A+M
- 00/11: A unchanged
- then arithmetic right shift of {A,Q,q_1} by one bit, with A's MSB replicated.
REQ-014 The add/subtract SHALL be WIDTH+1 bits wide so a = -2^(WIDTH-1) never overflows.
REQ-015 After exactly WIDTH CALC cycles (count reaching WIDTH-1), state SHALL go to DONE and product SHALL be loaded with {A[WIDTH-1:0],Q}.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE; busy SHALL be high exactly while in CALC.
REQ-017 Latency: with start accepted at rising edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-018 DONE SHALL return to IDLE on the next edge unless start is high, in which case a new multiply is accepted (back-to-back, no idle cycle).
REQ-019 product SHALL hold its value until the next DONE load; it SHALL NOT change during CALC.
REQ-020 The result SHALL equal the exact signed product for all 2^(2*WIDTH) operand pairs.

Reset
REQ-021 While rst is high, the block SHALL hold:
- state = IDLE, busy = 0, done = 0
- product = 0, A = 0, Q = 0, M = 0, q_1 = 0, count = 0
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first edge after release with start high SHALL begin a fresh multiply.

Configuration
REQ-023 The macro MULT_ZERO_BYPASS_EN SHALL control zero bypass:
- Defined: if a==0 or b==0 at acceptance, the block SHALL skip CALC, go directly to DONE with product = 0, and pulse done one cycle after the accepting edge; busy SHALL stay 0.
- Undefined: every multiply SHALL take the full WIDTH-cycle latency.

Structure
REQ-024 A shared package mult_pkg SHALL hold the FSM state typedef (IDLE/CALC/DONE), the Booth operation encoding (NOP/ADD/SUB), and the default WIDTH constant.
REQ-025 The WIDTH+1-bit add/subtract SHALL be a sub-module booth_addsub (inputs x, y, sub; output s), combinational; the FSM, counter and shift registers SHALL live in booth_seq_mult.

Verification
REQ-026 WIDTH=8, a=3, b=5, start one cycle -> done pulse 8 cycles after the accepting edge; product=0x000F; busy high 8 cycles.
REQ-027 a=-128, b=-128 -> product=0x4000; a=-128, b=127 -> product=0xC080; a=-1, b=-1 -> product=0x0001.
REQ-028 Start during CALC with different operands -> ignored; first result unchanged; exactly one done pulse.
REQ-029 Start held high through DONE with new operands 7 and -2 -> second multiply starts with no idle cycle; product=0xFFF2 on the second done.
REQ-030 rst pulsed at CALC cycle 4 -> busy=0, done=0 and product=0 immediately, with no done pulse afterward; then a=0, b=9 -> product=0x0000.
- With MULT_ZERO_BYPASS_EN: done one cycle after acceptance.
- Without it: done after 8 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states,
// Booth operation encoding and the default operand width.
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}
  function automatic booth_op_t booth_decode(input logic q0, input logic q1);
    booth_op_t op;
    case ({q0, q1})
      2'b10:   op = SUB;
      2'b01:   op = ADD;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational signed add/subtract used by the Booth step; sized one bit wider
// than the operands by the instantiating module so the most negative value fits.
module booth_addsub #(
  parameter int W = 9
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic                sub,
  output logic signed [W-1:0] s
);

  always_comb begin
    s = sub ? (x - y) : (x + y);
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier, one Booth step per clock.
// Optional feature macro: MULT_ZERO_BYPASS_EN (zero operands skip the CALC phase).
module booth_seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t                    state_q, state_d;
  logic signed [WIDTH:0]     m_q, m_d;
  logic signed [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]          q_q, q_d;
  logic                      q1_q, q1_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH-1:0]        product_q, product_d;

  logic                      accept;
  logic                      bypass;
  logic                      last;
  booth_op_t                 op;
  logic signed [WIDTH:0]     sum;
  logic signed [WIDTH:0]     a_sel;
  logic signed [WIDTH:0]     a_sh;
  logic [WIDTH-1:0]          q_sh;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULT_ZERO_BYPASS_EN
  assign bypass = (a == '0) || (b == '0);
`else
  assign bypass = 1'b0;
`endif

  // Booth step: conditional add/sub of M into A, then arithmetic shift of {A,Q,q_1}
  assign op = booth_decode(q_q[0], q1_q);

  booth_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .x   (a_q),
    .y   (m_q),
    .sub (op == SUB),
    .s   (sum)
  );

  assign a_sel = (op == NOP) ? a_q : sum;
  assign a_sh  = {a_sel[WIDTH], a_sel[WIDTH:1]};
  assign q_sh  = {a_sel[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = bypass ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_comb begin
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      m_d   = {a[WIDTH-1], a};
      q_d   = b;
      a_d   = '0;
      q1_d  = 1'b0;
      cnt_d = '0;
      if (bypass) begin
        product_d = '0;
      end
    end else if (state_q == CALC) begin
      a_d   = a_sh;
      q_d   = q_sh;
      q1_d  = q_q[0];
      cnt_d = cnt_q + 1'b1;
      // After the final shift A's top bit is pure sign, so {A[W-1:0],Q} is exact
      if (last) begin
        product_d = {a_sh[WIDTH-1:0], q_sh};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=8) using an expected-product queue.
module tb_booth_seq_mult;

  localparam int W = 8;
`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZLAT  = 0;
  localparam int ZBUSY = 0;
`else
  localparam int ZLAT  = W;
  localparam int ZBUSY = W;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    return sx * sy;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    return ((x == '0) || (y == '0)) ? ZLAT : W;
  endfunction

  function automatic int exp_busy(input logic [W-1:0] x, input logic [W-1:0] y);
    return ((x == '0) || (y == '0)) ? ZBUSY : W;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge (j=0)
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    exp_q.push_back(ref_mul(x, y));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scans negedges from index j0 until done; lat=-1 if the budget expires
  task automatic wait_done(input int j0, output int lat, output int bcnt, output logic [2*W-1:0] got);
    lat  = -1;
    bcnt = 0;
    got  = '0;
    for (int j = j0; j <= j0 + W + 20; j++) begin
      if (done) begin
        lat = j;
        got = product;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd5;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (product !== '0) begin n_bad++; $display("FAIL reset_product got=%h exp=0000", product); end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcnt;
    logic [2*W-1:0] got, expv;
    issue(8'd3, 8'd5);
    wait_done(0, lat, bcnt, got);
    expv = exp_q.pop_front();
    n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
    n_cmp++; if (bcnt !== W) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bcnt, W); end
    n_cmp++; if (got !== 16'h000F) begin n_bad++; $display("FAIL basic_product got=%h exp=000F", got); end
    n_cmp++; if (got !== expv) begin n_bad++; $display("FAIL basic_model got=%h exp=%h", got, expv); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    n_cmp++; if (product !== expv) begin n_bad++; $display("FAIL basic_hold got=%h exp=%h", product, expv); end
  endtask

  task automatic test_corners;
    logic [W-1:0] ta[7] = '{8'h80, 8'h80, 8'hFF, 8'h7F, 8'h01, 8'h00, 8'h80};
    logic [W-1:0] tb[7] = '{8'h80, 8'h7F, 8'hFF, 8'h7F, 8'h80, 8'h33, 8'h01};
    int lat, bcnt;
    logic [2*W-1:0] got, expv;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i]);
      wait_done(0, lat, bcnt, got);
      expv = exp_q.pop_front();
      n_cmp++; if (got !== expv) begin n_bad++; $display("FAIL corner_product[%0d] got=%h exp=%h", i, got, expv); end
      n_cmp++; if (lat !== exp_lat(ta[i], tb[i])) begin n_bad++; $display("FAIL corner_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(ta[i], tb[i])); end
      n_cmp++; if (bcnt !== exp_busy(ta[i], tb[i])) begin n_bad++; $display("FAIL corner_busy[%0d] got=%0d exp=%0d", i, bcnt, exp_busy(ta[i], tb[i])); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt, ndone;
    logic [2*W-1:0] got, expv, prev;
    prev = product;
    issue(8'd10, 8'hFD);
    for (int j = 0; j < 3; j++) begin
      start = 1'b1;
      a     = 8'd99;
      b     = 8'd99;
      n_cmp++; if (product !== prev) begin n_bad++; $display("FAIL ignore_hold[%0d] got=%h exp=%h", j, product, prev); end
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(3, lat, bcnt, got);
    expv = exp_q.pop_front();
    n_cmp++; if (got !== expv) begin n_bad++; $display("FAIL ignore_product got=%h exp=%h", got, expv); end
    n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W); end
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL ignore_extra_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    logic [2*W-1:0] got, expv;
    issue(8'd5, 8'd6);
    wait_done(0, lat, bcnt, got);
    expv = exp_q.pop_front();
    n_cmp++; if (got !== expv) begin n_bad++; $display("FAIL b2b_first got=%h exp=%h", got, expv); end
    issue(8'd7, 8'hFE);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_no_idle got=%b exp=1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_low got=%b exp=0", done); end
    wait_done(0, lat, bcnt, got);
    expv = exp_q.pop_front();
    n_cmp++; if (got !== 16'hFFF2) begin n_bad++; $display("FAIL b2b_second got=%h exp=FFF2", got); end
    n_cmp++; if (lat !== W) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, W); end
    n_cmp++; if (got !== expv) begin n_bad++; $display("FAIL b2b_model got=%h exp=%h", got, expv); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, ndone;
    logic [2*W-1:0] got, expv;
    issue(8'd50, 8'hEC);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b exp=0", done); end
    n_cmp++; if (product !== '0) begin n_bad++; $display("FAIL midrst_product got=%h exp=0000", product); end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL midrst_activity got=%0d exp=0", ndone); end
    issue(8'd0, 8'd9);
    wait_done(0, lat, bcnt, got);
    expv = exp_q.pop_front();
    n_cmp++; if (got !== 16'h0000) begin n_bad++; $display("FAIL midrst_zero_product got=%h exp=0000", got); end
    n_cmp++; if (got !== expv) begin n_bad++; $display("FAIL midrst_model got=%h exp=%h", got, expv); end
    n_cmp++; if (lat !== ZLAT) begin n_bad++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, ZLAT); end
    n_cmp++; if (bcnt !== ZBUSY) begin n_bad++; $display("FAIL midrst_busy_cycles got=%0d exp=%0d", bcnt, ZBUSY); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, bcnt;
    logic [W-1:0] x, y;
    logic [2*W-1:0] got, expv;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      issue(x, y);
      wait_done(0, lat, bcnt, got);
      expv = exp_q.pop_front();
      n_cmp++; if (got !== expv) begin n_bad++; $display("FAIL rand_product[%0d] a=%h b=%h got=%h exp=%h", i, x, y, got, expv); end
      n_cmp++; if (lat !== exp_lat(x, y)) begin n_bad++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(x, y)); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_corners;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL queue_drained got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
